// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard/stall controller for the 5-stage RV64 pipeline
// Resolves load-use, taken-branch and data-memory-wait hazards with a wait timeout and perf counters.
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    localparam logic [7:0]       WAIT_LIM = 8'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t     cur;
    logic [7:0] wait_cnt;
    logic       load_use;
    logic       frozen;

    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // A busy memory freezes everything in RUN and MEM_WAIT alike; once it
    // drops, MEM_WAIT releases in the same cycle with the normal RUN response.
    assign frozen = (cur == TIMEOUT) || mem_busy;

    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_we    = 1'b1;
        idex_flush = 1'b0;
        exmem_we   = 1'b1;
        if (reset) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (frozen) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= RUN;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            case (cur)
                RUN: begin
                    if (mem_busy) begin
                        cur      <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_busy) begin
                        cur      <= RUN;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == WAIT_LIM) begin
                        cur         <= TIMEOUT;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    cur         <= TIMEOUT;
                    mem_timeout <= 1'b1;
                end
            endcase
            if (!pc_we && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (idex_flush && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken, mem_busy;
    logic             pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, mem_timeout;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
        .idex_flush(idex_flush), .exmem_we(exmem_we), .mem_timeout(mem_timeout),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             chk_all;
        logic [5:0]       ctl;
        logic             to;
        logic [1:0]       st;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: consecutive busy cycles seen, sticky timeout, counts.
    bit known     = 0;
    int busy_run  = 0;
    bit timed_out = 0;
    int m_stall   = 0;
    int m_flush   = 0;

    task automatic step(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit u1, input bit u2, input bit mr, input logic [4:0] rd,
                        input bit br, input bit mb);
        exp_t e;
        bit   lu;
        bit   pw, iw, ifl, xw, xfl, mw;
        @(posedge clk);
        #1;
        reset = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_memread = mr; ex_rd = rd; ex_branch_taken = br; mem_busy = mb;
        lu = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (r)                   {pw, iw, ifl, xw, xfl, mw} = 6'b000101;
        else if (timed_out || mb) {pw, iw, ifl, xw, xfl, mw} = 6'b000000;
        else if (br)             {pw, iw, ifl, xw, xfl, mw} = 6'b111111;
        else if (lu)             {pw, iw, ifl, xw, xfl, mw} = 6'b000111;
        else                     {pw, iw, ifl, xw, xfl, mw} = 6'b110101;
        e.chk_all = known;
        e.ctl     = {pw, iw, ifl, xw, xfl, mw};
        e.to      = timed_out;
        e.st      = timed_out ? 2'd2 : (busy_run > 0 ? 2'd1 : 2'd0);
        e.sc      = CNT_W'(m_stall);
        e.fc      = CNT_W'(m_flush);
        exp_q.push_back(e);
        if (r) begin
            known = 1; busy_run = 0; timed_out = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!pw) m_stall = (m_stall < CNT_SAT) ? m_stall + 1 : CNT_SAT;
            if (xfl) m_flush = (m_flush < CNT_SAT) ? m_flush + 1 : CNT_SAT;
            if (!timed_out) begin
                busy_run = mb ? busy_run + 1 : 0;
                if (busy_run > MAX_WAIT) timed_out = 1;
            end
        end
    endtask

    task automatic idle(input bit mb);
        step(0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, mb);
    endtask

    // Monitor: the DUT presents a response every cycle; sample mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we} !== e.ctl) begin
                n_fail++;
                $display("FAIL ctl cyc=%0d got=%b exp=%b (pc,ifid,ifidfl,idex,idexfl,exmem)",
                         cyc, {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we}, e.ctl);
            end
            if (e.chk_all) begin
                n_checks++;
                if ({mem_timeout, state, stall_cnt, flush_cnt} !== {e.to, e.st, e.sc, e.fc}) begin
                    n_fail++;
                    $display("FAIL status cyc=%0d got to=%b st=%0d sc=%0d fc=%0d exp to=%b st=%0d sc=%0d fc=%0d",
                             cyc, mem_timeout, state, stall_cnt, flush_cnt, e.to, e.st, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        int burst;
        int guard;
        reset = 1; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_memread = 0; ex_rd = 0; ex_branch_taken = 0; mem_busy = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // load-use on rs2, then clear
        step(0, 5'd3, 5'd5, 0, 1, 1, 5'd5, 0, 0);
        step(0, 5'd3, 5'd5, 0, 1, 0, 5'd5, 0, 0);
        // branch wins over load-use
        step(0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0);
        // x0 and unused-operand filters
        step(0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0);
        step(0, 5'd7, 5'd1, 0, 1, 1, 5'd7, 0, 0);
        // 3-cycle memory wait with a branch pending through it
        repeat (3) step(0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 1);
        step(0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 0);
        idle(0);
        // timeout: 20 busy cycles then idle, frozen until reset
        repeat (20) idle(1);
        repeat (3) idle(0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        // saturation: 20 load-use stalls
        repeat (20) step(0, 5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 0);
        idle(0);
        // reset in the middle of a memory wait
        repeat (4) idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        // randomized traffic
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            bit mb;
            if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(1, 20);
            mb = (burst > 0);
            if (burst > 0) burst--;
            step($urandom_range(0, 199) == 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 7) == 0, mb);
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
